// File: rtl/cpu_types_pkg.sv
// Shared cache types: address split, frame layout and icache FSM states.
// Widths here describe the default 16-set, 32-bit configuration.
package cpu_types_pkg;
   localparam int ICACHE_SETS   = 16;
   localparam int ICACHE_WORD_W = 32;
   localparam int ICACHE_IDX_W  = $clog2(ICACHE_SETS);
   localparam int ICACHE_TAG_W  = ICACHE_WORD_W - ICACHE_IDX_W - 2;

   typedef struct packed {
      logic [ICACHE_TAG_W-1:0] tag;
      logic [ICACHE_IDX_W-1:0] idx;
      logic [1:0]              bytoff;
   } icachef_t;

   typedef struct packed {
      logic                     valid;
      logic [ICACHE_TAG_W-1:0]  tag;
      logic [ICACHE_WORD_W-1:0] data;
   } icache_frame_t;

   typedef enum logic {
      COMPARE = 1'b0,
      FILL    = 1'b1
   } icache_state_t;
endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: async read by index, one sync write port.
// Reset clears only the valid bits; tag and data are don't-care until filled.
module icache_frame_array #(
   parameter int SETS   = 16,
   parameter int WORD_W = 32,
   parameter int IDX_W  = $clog2(SETS),
   parameter int TAG_W  = WORD_W - IDX_W - 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [WORD_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [WORD_W-1:0] wr_data
);
   logic [SETS-1:0]   valid;
   logic [TAG_W-1:0]  tags [SETS];
   logic [WORD_W-1:0] data [SETS];

   // Reset wins over a same-cycle fill write
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
         tags[wr_idx]  <= wr_tag;
         data[wr_idx]  <= wr_data;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_data  = data[rd_idx];
endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with COMPARE/FILL miss handling.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_direct
   import cpu_types_pkg::*;
#(
   parameter int SETS   = 16,
   parameter int WORD_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              imemREN,
   input  logic [WORD_W-1:0] imemaddr,
   output logic              ihit,
   output logic [WORD_W-1:0] imemload,
   output logic              iREN,
   output logic [WORD_W-1:0] iaddr,
   input  logic              iwait,
   input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = WORD_W - IDX_W - 2;

   icache_state_t     state, next_state;
   logic [WORD_W-1:0] miss_addr;
   logic              latch_miss;
   logic              wr_en;
   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [WORD_W-1:0] rd_data;
   logic [IDX_W-1:0]  cur_idx;
   logic [TAG_W-1:0]  cur_tag;
   logic              match;

   assign cur_idx = imemaddr[IDX_W+1:2];
   assign cur_tag = imemaddr[WORD_W-1:IDX_W+2];
   assign match   = rd_valid && (rd_tag == cur_tag);

   icache_frame_array #(
      .SETS   (SETS),
      .WORD_W (WORD_W),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W)
   ) u_frames (
      .clk      (CLK),
      .rst      (RST),
      .rd_idx   (cur_idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_idx   (miss_addr[IDX_W+1:2]),
      .wr_tag   (miss_addr[WORD_W-1:IDX_W+2]),
      .wr_data  (iload)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= COMPARE;
         miss_addr <= '0;
      end else begin
         state <= next_state;
         if (latch_miss)
            miss_addr <= {imemaddr[WORD_W-1:2], 2'b00};
      end
   end

   always_comb begin
      next_state = state;
      latch_miss = 1'b0;
      wr_en      = 1'b0;
      ihit       = 1'b0;
      imemload   = '0;
      iREN       = 1'b0;
      iaddr      = '0;
      if (!RST) begin
         unique case (state)
            COMPARE: begin
               if (imemREN && match) begin
                  ihit     = 1'b1;
                  imemload = rd_data;
               end else if (imemREN) begin
                  latch_miss = 1'b1;
                  next_state = FILL;
               end
            end
            FILL: begin
               iREN  = 1'b1;
               iaddr = miss_addr;
               if (!iwait) begin
                  wr_en      = 1'b1;
                  next_state = COMPARE;
               end
            end
            default: next_state = COMPARE;
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (ihit && hit_count != 32'hFFFF_FFFF)
            hit_count <= hit_count + 32'd1;
         if (latch_miss && miss_count != 32'hFFFF_FFFF)
            miss_count <= miss_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_icache_direct.sv
// Scenario bench for icache_direct: expected fetch words queue on issue
// and are popped when ihit is seen; memory_control is driven by hand.
module tb_icache_direct;
   logic        CLK;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int          vectors;
   int          miscompares;
   logic [31:0] exp_q[$];
   logic [31:0] exp;

   icache_direct dut (
      .CLK      (CLK),
      .RST      (RST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w == 32'h40)
         return 32'h2401_0005;
      return {w[15:0] ^ 16'hBEEF, w[15:0]};
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Hit expected in the current cycle; checks data via the scoreboard
   task automatic test_hit(input logic [31:0] a);
      imemREN  = 1'b1;
      imemaddr = a;
      exp_q.push_back(mem(a));
      @(negedge CLK);
      vectors++;
      if (ihit !== 1'b1 || iREN !== 1'b0) begin
         miscompares++;
         $display("FAIL hit_%h: ihit=%b iREN=%b want ihit=1 iREN=0",
                  a, ihit, iREN);
      end
      if (ihit === 1'b1) begin
         exp = exp_q.pop_front();
         vectors++;
         if (imemload !== exp) begin
            miscompares++;
            $display("FAIL hit_data_%h: got %h want %h", a, imemload, exp);
         end
      end else begin
         void'(exp_q.pop_front());
      end
      step();
   endtask

   // Miss, fill after `waits` busy cycles, then replay hit
   task automatic test_miss(input logic [31:0] a, input int waits);
      logic [31:0] wa;
      wa       = {a[31:2], 2'b00};
      imemREN  = 1'b1;
      imemaddr = a;
      exp_q.push_back(mem(a));
      @(negedge CLK);
      vectors++;
      if (ihit !== 1'b0 || iREN !== 1'b0) begin
         miscompares++;
         $display("FAIL miss_cmp_%h: ihit=%b iREN=%b want 0 0", a, ihit, iREN);
      end
      step();
      for (int i = 0; i <= waits; i++) begin
         if (i == waits) begin
            iwait = 1'b0;
            iload = mem(a);
         end
         @(negedge CLK);
         vectors++;
         if (iREN !== 1'b1 || iaddr !== wa || ihit !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_%h_c%0d: iREN=%b iaddr=%h ihit=%b want 1 %h 0",
                     a, i, iREN, iaddr, ihit, wa);
         end
         step();
      end
      iwait = 1'b1;
      iload = 32'h0;
      @(negedge CLK);
      vectors++;
      if (ihit !== 1'b1 || iREN !== 1'b0) begin
         miscompares++;
         $display("FAIL replay_%h: ihit=%b iREN=%b want 1 0", a, ihit, iREN);
         void'(exp_q.pop_front());
      end else begin
         exp = exp_q.pop_front();
         vectors++;
         if (imemload !== exp) begin
            miscompares++;
            $display("FAIL replay_data_%h: got %h want %h", a, imemload, exp);
         end
      end
      step();
   endtask

   task automatic test_reset();
      RST      = 1'b1;
      imemREN  = 1'b1;
      imemaddr = 32'h40;
      iwait    = 1'b1;
      iload    = 32'h0;
      step();
      step();
      @(negedge CLK);
      vectors++;
      if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0 || iaddr !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_out: ihit=%b imemload=%h iREN=%b iaddr=%h want zeros",
                  ihit, imemload, iREN, iaddr);
      end
      step();
      RST     = 1'b0;
      imemREN = 1'b0;
   endtask

   task automatic test_idle();
      imemREN  = 1'b0;
      imemaddr = 32'h40;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         vectors++;
         if (ihit !== 1'b0 || iREN !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_c%0d: ihit=%b iREN=%b want 0 0", i, ihit, iREN);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      test_hit(32'h40);
      test_hit(32'h41);
      test_hit(32'h42);
      test_hit(32'h43);
   endtask

   task automatic test_conflict();
      test_miss(32'h80, 1);
      test_hit(32'h80);
      test_miss(32'h40, 0);
   endtask

   task automatic test_addr_change();
      imemREN  = 1'b1;
      imemaddr = 32'h100;
      @(negedge CLK);
      vectors++;
      if (ihit !== 1'b0) begin
         miscompares++;
         $display("FAIL chg_miss: ihit=%b want 0", ihit);
      end
      step();
      // 0x40 is resident in frame 0, yet FILL must not report a hit
      imemaddr = 32'h40;
      @(negedge CLK);
      vectors++;
      if (ihit !== 1'b0 || iREN !== 1'b1 || iaddr !== 32'h100) begin
         miscompares++;
         $display("FAIL chg_fill_hit: ihit=%b iREN=%b iaddr=%h want 0 1 00000100",
                  ihit, iREN, iaddr);
      end
      step();
      imemaddr = 32'h104;
      imemREN  = 1'b0;
      @(negedge CLK);
      vectors++;
      if (iREN !== 1'b1 || iaddr !== 32'h100) begin
         miscompares++;
         $display("FAIL chg_hold: iREN=%b iaddr=%h want 1 00000100", iREN, iaddr);
      end
      step();
      imemREN = 1'b1;
      iwait   = 1'b0;
      iload   = mem(32'h100);
      step();
      iwait = 1'b1;
      iload = 32'h0;
      test_miss(32'h104, 2);
      test_hit(32'h100);
   endtask

   task automatic test_reset_mid_fill();
      imemREN  = 1'b1;
      imemaddr = 32'h200;
      step();
      iwait = 1'b0;
      iload = 32'hDEAD_BEEF;
      RST   = 1'b1;
      step();
      RST     = 1'b0;
      iwait   = 1'b1;
      iload   = 32'h0;
      imemREN = 1'b0;
      @(negedge CLK);
      vectors++;
      if (iREN !== 1'b0 || ihit !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_fill: iREN=%b ihit=%b want 0 0", iREN, ihit);
      end
      step();
      test_miss(32'h200, 1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_miss(32'h40, 3);
      test_hit(32'h40);
`ifdef ICACHE_STATS_EN
      vectors++;
      if (miss_count !== 32'd1 || hit_count < 32'd2) begin
         miscompares++;
         $display("FAIL stats: miss_count=%0d hit_count=%0d want 1 and >=2",
                  miss_count, hit_count);
      end
`endif
      test_hit(32'h43);
      test_idle();
      test_back_to_back();
      test_conflict();
      test_addr_change();
      test_reset_mid_fill();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_left: %0d entries want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
